// File: rtl/irrigation_valve_driver.sv
`default_nettype none
// ============================================================================
// Module   : irrigation_valve_driver
// Purpose  : Actuator stage behind the irrigation selector. It filters mode
//            chatter, holds each valve open for a minimum on-time, and inserts
//            a closed dead time between any valve closing and the next valve
//            opening. Controller disable overrides all of this.
// Ports    : clock             - system clock, rising edge
//            reset_n           - asynchronous active-low reset
//            irrigation_enable - controller permission (0 closes the valves)
//            splinker_mode_on  - selector request (1 sprinkler, 0 dripper)
//            splinker_valve    - sprinkler valve open
//            dripper_valve     - dripper valve open
//            busy              - dead time in progress
// Revision : 1.0 - initial release
// ============================================================================
module irrigation_valve_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEADTIME_CYCLES = 8,
    parameter int MIN_ON_CYCLES   = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic irrigation_enable,
    input  logic splinker_mode_on,
    output logic splinker_valve,
    output logic dripper_valve,
    output logic busy
);

    localparam int c_DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_DT_W  = $clog2(DEADTIME_CYCLES + 1);
    localparam int c_ON_W  = $clog2(MIN_ON_CYCLES + 1);

    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_ONE  = c_DEB_W'(1);
    localparam logic [c_DT_W-1:0]  c_DT_LAST  = c_DT_W'(DEADTIME_CYCLES - 1);
    localparam logic [c_DT_W-1:0]  c_DT_ONE   = c_DT_W'(1);
    localparam logic [c_ON_W-1:0]  c_MIN_ON   = c_ON_W'(MIN_ON_CYCLES);
    localparam logic [c_ON_W-1:0]  c_ON_ONE   = c_ON_W'(1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_SPRINKLER = 2'd1;
    localparam logic [1:0] c_ST_DRIPPER   = 2'd2;
    localparam logic [1:0] c_ST_DEADTIME  = 2'd3;

    logic               r_en_meta;
    logic               r_en_s;
    logic               r_mode_meta;
    logic               r_mode_s;
    logic               r_mode_f;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [1:0]         r_state;
    logic [c_ON_W-1:0]  r_on_cnt;
    logic [c_DT_W-1:0]  r_dt_cnt;
    logic               w_mode_mismatch;
    logic [1:0]         w_mode_state;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for both asynchronous controller inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en_meta   <= 1'b0;
            r_en_s      <= 1'b0;
            r_mode_meta <= 1'b0;
            r_mode_s    <= 1'b0;
        end else begin
            r_en_meta   <= irrigation_enable;
            r_en_s      <= r_en_meta;
            r_mode_meta <= splinker_mode_on;
            r_mode_s    <= r_mode_meta;
        end
    end

    // ------------------------------------------------------------------
    // Mode filter: a new mode is accepted only after it has differed from
    // the filtered mode for DEBOUNCE_CYCLES consecutive samples. Any
    // sample that agrees again restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode_f  <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_mode_s == r_mode_f) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_DEB_LAST) begin
            r_mode_f  <= r_mode_s;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
        end
    end

    // The open-valve state disagrees with the filtered request
    assign w_mode_mismatch = r_mode_f != (r_state == c_ST_SPRINKLER);
    // Valve state selected by the filtered request
    assign w_mode_state    = r_mode_f ? c_ST_SPRINKLER : c_ST_DRIPPER;

    // ------------------------------------------------------------------
    // Valve sequencer. Every path from an open valve to another open valve
    // passes through DEADTIME; only IDLE (reached by reset or after a dead
    // time) may open a valve directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_on_cnt <= '0;
            r_dt_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_en_s) begin
                        r_state  <= w_mode_state;
                        r_on_cnt <= '0;
                    end
                end
                c_ST_SPRINKLER, c_ST_DRIPPER: begin
                    // Saturating on-time counter; it never wraps
                    if (r_on_cnt != c_MIN_ON) begin
                        r_on_cnt <= r_on_cnt + c_ON_ONE;
                    end
                    // Disable closes at once, a mode switch waits for min-on
                    if (!r_en_s || (w_mode_mismatch && (r_on_cnt == c_MIN_ON))) begin
                        r_state  <= c_ST_DEADTIME;
                        r_dt_cnt <= c_DT_LAST;
                    end
                end
                c_ST_DEADTIME: begin
                    // The filtered mode is sampled only at exit, so a request
                    // that reverted during the dead time reopens the old valve
                    if (r_dt_cnt == '0) begin
                        if (r_en_s) begin
                            r_state  <= w_mode_state;
                            r_on_cnt <= '0;
                        end else begin
                            r_state  <= c_ST_IDLE;
                        end
                    end else begin
                        r_dt_cnt <= r_dt_cnt - c_DT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so the valves are mutually
    // exclusive by construction and reset closes them asynchronously
    assign splinker_valve = (r_state == c_ST_SPRINKLER);
    assign dripper_valve  = (r_state == c_ST_DRIPPER);
    assign busy           = (r_state == c_ST_DEADTIME);

endmodule
`default_nettype wire

// File: tb/tb_irrigation_valve_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_irrigation_valve_driver
// Purpose  : Self-checking bench for irrigation_valve_driver. A reference
//            model derives the expected valve/busy outputs from the input
//            history and elapsed-time rules; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irrigation_valve_driver;

    localparam int DEB = 4;
    localparam int DT  = 8;
    localparam int MON = 16;

    localparam int P_IDLE = 0;
    localparam int P_SPR  = 1;
    localparam int P_DRIP = 2;
    localparam int P_DEAD = 3;

    logic clk;
    logic reset_n;
    logic en;
    logic mode;
    logic spr_v;
    logic drip_v;
    logic busy_v;

    int n_checks = 0;
    int n_fail   = 0;

    irrigation_valve_driver #(
        .DEBOUNCE_CYCLES (DEB),
        .DEADTIME_CYCLES (DT),
        .MIN_ON_CYCLES   (MON)
    ) dut (
        .clock             (clk),
        .reset_n           (reset_n),
        .irrigation_enable (en),
        .splinker_mode_on  (mode),
        .splinker_valve    (spr_v),
        .dripper_valve     (drip_v),
        .busy              (busy_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: raw inputs are recorded per rising edge (edge k holds
    // index k). Synchronizers are a two-edge delay, the filter is a window
    // test over the last DEB synchronized samples, and the sequencer tracks
    // the edge at which each phase began instead of counters.
    // ------------------------------------------------------------------
    bit      en_h[$];
    bit      mode_h[$];
    logic [2:0] exp_q[$];
    int      k;
    bit      mf;
    int      ph;
    int      t_open;
    int      t_dead;

    function automatic bit raw_en(input int idx);
        if (idx < 1 || idx > en_h.size()) return 1'b0;
        return en_h[idx-1];
    endfunction

    function automatic bit raw_mode(input int idx);
        if (idx < 1 || idx > mode_h.size()) return 1'b0;
        return mode_h[idx-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit en_prev;
        bit mf_prev;
        bit flip;
        if (!reset_n) begin
            k = 0;
            en_h.delete();
            mode_h.delete();
            exp_q.delete();
            mf     = 1'b0;
            ph     = P_IDLE;
            t_open = 0;
            t_dead = 0;
        end else begin
            k++;
            en_h.push_back(en);
            mode_h.push_back(mode);
            en_prev = raw_en(k - 2);
            mf_prev = mf;
            // Accept a new mode once DEB consecutive synchronized samples differ
            flip = 1'b1;
            for (int j = k - DEB + 1; j <= k; j++) begin
                if (raw_mode(j - 2) == mf_prev) flip = 1'b0;
            end
            if (flip) mf = ~mf_prev;
            case (ph)
                P_IDLE: begin
                    if (en_prev) begin
                        ph     = mf_prev ? P_SPR : P_DRIP;
                        t_open = k;
                    end
                end
                P_SPR, P_DRIP: begin
                    if (!en_prev ||
                        ((mf_prev != (ph == P_SPR)) && (k - 1 - t_open >= MON))) begin
                        ph     = P_DEAD;
                        t_dead = k;
                    end
                end
                default: begin
                    if (k - t_dead == DT) begin
                        if (en_prev) begin
                            ph     = mf_prev ? P_SPR : P_DRIP;
                            t_open = k;
                        end else begin
                            ph = P_IDLE;
                        end
                    end
                end
            endcase
            exp_q.push_back({ph == P_SPR, ph == P_DRIP, ph == P_DEAD});
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares on falling edges, plus just after reset assertion
    // ------------------------------------------------------------------
    int closed_run;
    bit had_open;
    bit prev_open;

    always @(negedge clk or negedge reset_n) begin
        logic [2:0] got;
        logic [2:0] exp;
        #1;
        got = {spr_v, drip_v, busy_v};
        if (!reset_n) begin
            n_checks++;
            if (got !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs: got spr/drip/busy=%b required 000 at %0t", got, $time);
            end
            closed_run = 0;
            had_open   = 1'b0;
            prev_open  = 1'b0;
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs: got spr/drip/busy=%b required %b at %0t", got, exp, $time);
            end
            n_checks++;
            if (spr_v === 1'b1 && drip_v === 1'b1) begin
                n_fail++;
                $display("FAIL both_open: got spr=%b drip=%b required not both 1 at %0t",
                         spr_v, drip_v, $time);
            end
            if ((spr_v | drip_v) === 1'b1) begin
                if (!prev_open && had_open) begin
                    n_checks++;
                    if (closed_run < DT) begin
                        n_fail++;
                        $display("FAIL dead_gap: got %0d closed cycles required >= %0d at %0t",
                                 closed_run, DT, $time);
                    end
                end
                had_open   = 1'b1;
                prev_open  = 1'b1;
                closed_run = 0;
            end else begin
                prev_open = 1'b0;
                closed_run++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit e, input bit m, input int n);
        en   = e;
        mode = m;
        hold(n);
    endtask

    initial begin
        int cyc;
        int h;
        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        hold(3);
        reset_n = 1'b1;

        drive(1, 0, 25);               // dripper opens, min-on reached
        drive(1, 1, 30);               // switch to sprinkler through dead time
        drive(1, 0, 3);                // 3-cycle glitch: ignored
        drive(1, 1, 25);
        drive(0, 1, 5);                // disable, then re-enable inside dead time
        drive(1, 1, 3);
        drive(1, 0, 40);               // early mode change: waits for min-on
        drive(0, 0, 20);               // disable to IDLE
        drive(1, 1, 4);                // sprinkler from IDLE
        drive(1, 1, 30);
        drive(1, 0, 12);               // switch request that reverts in dead time
        drive(1, 1, 30);
        drive(1, 0, 2);                // simultaneous mode change and disable
        drive(0, 0, 20);
        drive(1, 0, 10);

        // Mid-run reset closes the open valve immediately
        #2 reset_n = 1'b0;
        hold(2);
        reset_n = 1'b1;
        drive(1, 1, 10);

        cyc = 0;
        while (cyc < 10000) begin
            if ($urandom_range(0, 3) == 0) h = $urandom_range(1, 3);
            else                           h = $urandom_range(4, 40);
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1), h);
            cyc += h;
        end
        drive(0, 0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion required completion by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
